// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encodings and default parameters for uart_tx_arbiter
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// rtl/uart_tx_arbiter_byte_fifo.sv - per-requester byte FIFO with occupancy-derived full/empty
module byte_fifo
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    // Full comes from the occupancy register, so a same-cycle pop never frees a slot for a push.
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART byte transmitter between two producers
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_done,
    output logic       tx_src,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          prio;
    logic [CW-1:0] cnt;
    logic [7:0]    rd_data0;
    logic [7:0]    rd_data1;
    logic          empty0;
    logic          empty1;
    logic          full0;
    logic          full1;
    logic          pop;
    logic          grant;
    logic          rd_en0;
    logic          rd_en1;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (req0_valid),
        .wr_data (req0_data),
        .rd_en   (rd_en0),
        .rd_data (rd_data0),
        .empty   (empty0),
        .full    (full0)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (req1_valid),
        .wr_data (req1_data),
        .rd_en   (rd_en1),
        .rd_data (rd_data1),
        .empty   (empty1),
        .full    (full1)
    );

    // prio names the requester that wins a tie; a lone non-empty FIFO always wins.
    always_comb begin
        pop    = (state == ST_IDLE) && !tx_done && (!empty0 || !empty1);
        grant  = (!empty0 && !empty1) ? prio : empty0;
        rd_en0 = pop && !grant;
        rd_en1 = pop && grant;
    end

    assign req0_ready = !full0;
    assign req1_ready = !full1;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            prio        <= 1'b0;
            cnt         <= '0;
            tx_data     <= 8'h00;
            tx_send     <= 1'b0;
            tx_src      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= grant ? rd_data1 : rd_data0;
                        tx_src  <= grant;
                        tx_send <= 1'b1;
                        prio    <= !grant;
                        cnt     <= '0;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        tx_send <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        tx_send     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    // Hold off the next byte until the transmitter has dropped done.
                    if (!tx_done) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_done;
    logic       tx_src;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_data   (req0_data),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req1_data   (req1_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_done     (tx_done),
        .tx_src      (tx_src),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic serve(input logic [7:0] d, input logic s);
        int n = 0;
        while (tx_send !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("serve_send", tx_send, 1);
        check("serve_data", tx_data, d);
        check("serve_src", tx_src, s);
        tx_done = 1'b1;
        tick();
        check("serve_drop", tx_send, 0);
        tx_done = 1'b0;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_data  = 8'h00;
        req0_valid = 1'b0;
        req1_data  = 8'h00;
        req1_valid = 1'b0;
        tx_done    = 1'b0;
        tick();
        tick();
        check("rst_send", tx_send, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_src", tx_src, 0);
        check("rst_busy", busy, 0);
        check("rst_err", timeout_err, 0);
        check("rst_ready0", req0_ready, 1);
        check("rst_ready1", req1_ready, 1);
        rst_n = 1'b1;
        tick();

        // Basic transfer: done 5 cycles after send, held 2 cycles
        req0_data  = 8'h41;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("basic_no_send_yet", tx_send, 0);
        tick();
        check("basic_send", tx_send, 1);
        check("basic_data", tx_data, 8'h41);
        check("basic_src", tx_src, 0);
        check("basic_busy", busy, 1);
        repeat (4) tick();
        check("basic_send_hold", tx_send, 1);
        tx_done = 1'b1;
        tick();
        check("basic_send_fall", tx_send, 0);
        check("basic_busy_rel", busy, 1);
        tick();
        check("basic_busy_done_hi", busy, 1);
        tx_done = 1'b0;
        tick();
        check("basic_busy_low", busy, 0);

        // Fairness: preload both FIFOs while done is held high
        do_reset();
        tx_done    = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_data = 8'h41 + 8'(i);
            req1_data = 8'h61 + 8'(i);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("fair_stalled", tx_send, 0);
        tx_done = 1'b0;
        serve(8'h41, 1'b0);
        serve(8'h61, 1'b1);
        serve(8'h42, 1'b0);
        serve(8'h62, 1'b1);
        serve(8'h43, 1'b0);
        serve(8'h63, 1'b1);

        // Full FIFO: fifth push must be refused
        do_reset();
        tx_done    = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 8'hA0 + 8'(i);
            tick();
        end
        check("full_ready_after4", req0_ready, 0);
        req0_data = 8'hA4;
        tick();
        check("full_ready_after5", req0_ready, 0);
        req0_valid = 1'b0;
        tx_done    = 1'b0;
        serve(8'hA0, 1'b0);
        serve(8'hA1, 1'b0);
        serve(8'hA2, 1'b0);
        serve(8'hA3, 1'b0);
        repeat (5) tick();
        check("full_no_fifth", tx_send, 0);
        check("full_idle", busy, 0);
        check("full_ready_back", req0_ready, 1);

        // Timeout with TIMEOUT=16 and done held low
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'hB0;
        tick();
        req0_data  = 8'hB1;
        tick();
        req0_valid = 1'b0;
        check("to_send", tx_send, 1);
        check("to_data", tx_data, 8'hB0);
        repeat (15) tick();
        check("to_hold15", tx_send, 1);
        check("to_err_pre", timeout_err, 0);
        tick();
        check("to_fall16", tx_send, 0);
        check("to_err", timeout_err, 1);
        serve(8'hB1, 1'b0);
        check("to_err_sticky", timeout_err, 1);

        // Stuck done: second byte waits for done to drop
        req1_valid = 1'b1;
        req1_data  = 8'hC0;
        tick();
        req1_data  = 8'hC1;
        tick();
        req1_valid = 1'b0;
        check("stuck_send", tx_send, 1);
        check("stuck_data", tx_data, 8'hC0);
        check("stuck_src", tx_src, 1);
        tx_done = 1'b1;
        tick();
        check("stuck_ack", tx_send, 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("stuck_hold", tx_send, 0);
        end
        tx_done = 1'b0;
        tick();
        check("stuck_release", tx_send, 0);
        tick();
        check("stuck_resend", tx_send, 1);
        check("stuck_data2", tx_data, 8'hC1);
        check("stuck_src2", tx_src, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();

        // Reset mid-send with three bytes queued
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 8'hD0 + 8'(i);
            tick();
        end
        req0_valid = 1'b0;
        check("mid_send", tx_send, 1);
        check("mid_data", tx_data, 8'hD0);
        rst_n = 1'b0;
        #1;
        check("mid_async_send", tx_send, 0);
        check("mid_async_busy", busy, 0);
        check("mid_async_err", timeout_err, 0);
        check("mid_async_data", tx_data, 8'h00);
        check("mid_ready0", req0_ready, 1);
        check("mid_ready1", req1_ready, 1);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_no_send", tx_send, 0);
        check("mid_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART byte transmitter between two independent byte producers, for example the pushbutton message sender and a status reporter. Each producer pushes bytes into its own small FIFO. A round-robin arbiter picks the next byte and drives the transmitter's send/acknowledge handshake (send level raised with stable data, transmitter raises done). The block sits between the producer logic and the transmitter, in the same clock domain as the transmitter.

Parameters:
DEPTH, 4, entries per requester FIFO (power of two, 2..16)
TIMEOUT, 65535, clk cycles tx_send may stay high without tx_done before the byte is abandoned

Ports:
clk  input  1  system clock (same clock as the transmitter's handshake logic)
rst_n  input  1  asynchronous, active-low reset
req0_data  input  8  requester 0 byte
req0_valid  input  1  requester 0 push request
req0_ready  output  1  requester 0 FIFO not full
req1_data  input  8  requester 1 byte
req1_valid  input  1  requester 1 push request
req1_ready  output  1  requester 1 FIFO not full
tx_data  output  8  byte to transmitter, stable while tx_send=1
tx_send  output  1  send request level to transmitter
tx_done  input  1  transmitter acknowledge level
tx_src  output  1  requester index of the byte in flight
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky flag, set on timeout, cleared only by reset

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, both FIFOs are empty and the state is IDLE. Outputs: tx_send=0, tx_data=8'h00, tx_src=0, busy=0, timeout_err=0, req0_ready=1, req1_ready=1. The round-robin pointer is reset so that requester 0 has priority first.
- FIFO push: reqN_valid && reqN_ready at a rising edge writes reqN_data into FIFO N.
  - reqN_ready = !full. It is registered from occupancy, so a push is never accepted while full, even if a pop happens in the same cycle.
  - A push and a pop may hit the same FIFO in the same cycle; occupancy is then unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Arbitration happens only in IDLE.
  - If exactly one FIFO is non-empty, it wins.
  - If both are non-empty, the requester not granted last time wins.
  - The pointer updates on each grant.
- State machine states are IDLE, SEND and RELEASE.
  - IDLE: if a FIFO is non-empty (occupancy as seen at this edge), pop its head, load tx_data and tx_src, set tx_send=1 and go to SEND. A byte pushed into an empty FIFO at edge N is therefore popped at edge N+1, and tx_send is high after edge N+1. A push on the same edge as the IDLE check is not visible until the next edge.
  - SEND: tx_send stays 1 and tx_data stays stable. The timeout counter increments every cycle.
    - If tx_done=1 is sampled: tx_send=0, go to RELEASE.
    - Else, if the counter reaches TIMEOUT-1: tx_send=0, timeout_err=1, go to RELEASE. The byte is dropped and not retried.
  - RELEASE: wait for tx_done=0, then go to IDLE with the counter cleared. This forms a 4-phase handshake; the next send never starts while done is still high.
- Minimum spacing between two tx_send rising edges is 3 cycles (SEND, RELEASE, IDLE) when tx_done pulses for exactly 1 cycle.
- tx_done high while in IDLE is ignored. No pop occurs until tx_done is low; IDLE checks tx_done=0 as well as non-empty.
- Reset asserted mid-transfer drops tx_send immediately, flushes both FIFOs and clears timeout_err.
- busy = (state != IDLE).

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SEND=2'd1, RELEASE=2'd2) and the default DEPTH and TIMEOUT values.
- One sub-module, byte_fifo: parameter DEPTH; ports clk, rst_n, wr_en, wr_data[7:0], rd_en, rd_data[7:0], empty, full. It is instantiated twice.
- Arbitration and the state machine live in the top module.

Test Plan:
- Basic transfer: push 8'h41 on req0 while idle, with a transmitter model that asserts tx_done 5 cycles after tx_send and holds it 2 cycles. Required: tx_send rises 1 cycle after the push, tx_data=8'h41, tx_src=0; tx_send falls the cycle after tx_done is seen; busy returns low after tx_done falls.
- Fairness: preload req0 with 41,42,43 and req1 with 61,62,63 while the transmitter stalls, then release. Required send order: 41,61,42,62,43,63.
- Full FIFO: push 5 bytes to req0 back-to-back (DEPTH=4) while the transmitter stalls. Required: req0_ready=0 after the 4th push, the 5th byte is not accepted, and exactly 4 bytes are later sent in order.
- Timeout: run with TIMEOUT=16 and tx_done held at 0. Required: tx_send falls after 16 cycles, timeout_err=1 and stays set, and the next queued byte is sent afterwards.
- Stuck done: hold tx_done high for 10 cycles after an ack while a second byte is queued. Required: no new tx_send until 1 cycle after tx_done falls.
- Reset mid-send: assert rst_n=0 while tx_send=1 with 3 bytes queued. Required: tx_send=0 immediately (asynchronous), both FIFOs empty, req ready=1, and no send after reset is released.
